// File: rtl/ac_exec_sequencer.sv
// ac_exec_sequencer: owns AC, DR and E and walks one instruction at a time
// through IDLE -> (FETCH) -> (EXEC) -> IDLE. The operand is read into DR
// over a req/ack handshake. One ALU strobe is driven in EXEC, and the ALU
// result is written back into AC and E.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, a FETCH that
// sees no ack for TIMEOUT_CYCLES cycles is abandoned with done+err.
module ac_exec_sequencer #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              alu_and,
  output logic              alu_add,
  output logic              alu_lda,
  output logic              alu_cma,
  output logic              alu_cir,
  output logic              alu_cil,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] dr,
  output logic              e,
  output logic              cin,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_carry,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_LDA = 4'd2;
  localparam logic [3:0] OP_CMA = 4'd3;
  localparam logic [3:0] OP_CIR = 4'd4;
  localparam logic [3:0] OP_CIL = 4'd5;
  localparam logic [3:0] OP_CLA = 4'd6;
  localparam logic [3:0] OP_CLE = 4'd7;
  localparam logic [3:0] OP_CME = 4'd8;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_ac;
  logic [DATA_W-1:0] r_dr;
  logic              r_e;
  logic              r_done;
  logic              r_err;
  logic              w_timeout;

  // Reject a timeout length that cannot be counted.
  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  // Count ack-less FETCH cycles; the count is held at zero outside FETCH, so it starts clean on every entry.
  always_ff @(posedge clk) begin
    if (rst || r_state != S_FETCH) r_cnt <= '0;
    else if (!mem_rd_ack)          r_cnt <= r_cnt + CNT_W'(1);
  end

  assign w_timeout = (r_state == S_FETCH) && !mem_rd_ack &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and the one-hot ALU strobes, which are a function of state only.
  always_comb begin
    w_state_nxt = r_state;
    alu_and     = 1'b0;
    alu_add     = 1'b0;
    alu_lda     = 1'b0;
    alu_cma     = 1'b0;
    alu_cir     = 1'b0;
    alu_cil     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (opcode <= OP_LDA)      w_state_nxt = S_FETCH;
          else if (opcode <= OP_CIL) w_state_nxt = S_EXEC;
        end
      end
      S_FETCH: begin
        if (mem_rd_ack)     w_state_nxt = S_EXEC;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_EXEC: begin
        w_state_nxt = S_IDLE;
        case (r_op)
          OP_AND:  alu_and = 1'b1;
          OP_ADD:  alu_add = 1'b1;
          OP_LDA:  alu_lda = 1'b1;
          OP_CMA:  alu_cma = 1'b1;
          OP_CIR:  alu_cir = 1'b1;
          OP_CIL:  alu_cil = 1'b1;
          default: ;
        endcase
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers and the registered done/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= '0;
      r_addr <= '0;
      r_ac   <= '0;
      r_dr   <= '0;
      r_e    <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= opcode;
            r_addr <= addr;
            case (opcode)
              OP_AND, OP_ADD, OP_LDA, OP_CMA, OP_CIR, OP_CIL: ;
              OP_CLA: begin r_ac <= '0;   r_done <= 1'b1; end
              OP_CLE: begin r_e  <= 1'b0; r_done <= 1'b1; end
              OP_CME: begin r_e  <= ~r_e; r_done <= 1'b1; end
              default: begin r_done <= 1'b1; r_err <= 1'b1; end
            endcase
          end
        end
        S_FETCH: begin
          if (mem_rd_ack) r_dr <= mem_rdata;
          else if (w_timeout) begin
            r_done <= 1'b1;
            r_err  <= 1'b1;
          end
        end
        S_EXEC: begin
          r_ac   <= alu_data;
          r_done <= 1'b1;
          case (r_op)
            OP_ADD:  r_e <= alu_carry;
            OP_CIR:  r_e <= r_ac[0];
            OP_CIL:  r_e <= r_ac[DATA_W-1];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign mem_rd_req = (r_state == S_FETCH);
  assign mem_addr   = r_addr;
  assign busy       = (r_state != S_IDLE);
  assign ac         = r_ac;
  assign dr         = r_dr;
  assign e          = r_e;
  assign cin        = 1'b0;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_ac_exec_sequencer.sv
// Directed bench for ac_exec_sequencer with a behavioural model of the
// downstream adder/logic unit. Build with +define+MEM_TIMEOUT_EN to add the
// FETCH timeout case.
module tb_ac_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, mem_rd_ack, e, cin, busy, done, err;
  logic [3:0] opcode;
  logic [7:0] addr, mem_addr, mem_rdata, ac, dr, alu_data;
  logic       mem_rd_req, alu_carry;
  logic       alu_and, alu_add, alu_lda, alu_cma, alu_cir, alu_cil;
  logic [8:0] w_sum;
  logic [5:0] w_strb;
  int         checks = 0;
  int         failures = 0;
  int         n;

  always #5 clk = ~clk;

  ac_exec_sequencer #(.DATA_W(8), .ADDR_W(8), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .addr(addr),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rdata(mem_rdata), .alu_and(alu_and), .alu_add(alu_add),
    .alu_lda(alu_lda), .alu_cma(alu_cma), .alu_cir(alu_cir), .alu_cil(alu_cil),
    .ac(ac), .dr(dr), .e(e), .cin(cin), .alu_data(alu_data),
    .alu_carry(alu_carry), .busy(busy), .done(done), .err(err)
  );

  assign w_strb = {alu_and, alu_add, alu_lda, alu_cma, alu_cir, alu_cil};

  // Reference adder/logic unit driven by the sequencer's registers and strobes.
  always_comb begin
    w_sum     = {1'b0, ac} + {1'b0, dr} + {8'd0, cin};
    alu_data  = 8'h00;
    alu_carry = 1'b0;
    if (alu_and) alu_data = ac & dr;
    if (alu_add) begin alu_data = w_sum[7:0]; alu_carry = w_sum[8]; end
    if (alu_lda) alu_data = dr;
    if (alu_cma) alu_data = ~ac;
    if (alu_cir) alu_data = {e, ac[7:1]};
    if (alu_cil) alu_data = {ac[6:0], e};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a);
    start = 1'b1; opcode = op; addr = a;
    tick();
    start = 1'b0;
  endtask

  task automatic ack_with(input logic [7:0] d);
    mem_rd_ack = 1'b1; mem_rdata = d;
    tick();
    mem_rd_ack = 1'b0; mem_rdata = 8'h00;
  endtask

  // Load AC through LDA with an immediate ack, then retire it.
  task automatic load_ac(input logic [7:0] d);
    issue(4'd2, 8'h00);
    ack_with(d);
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = 4'd0; addr = 8'h00;
    mem_rd_ack = 1'b0; mem_rdata = 8'h00;
    tick(); tick();
    // Reset state
    chk("rst_ac", ac, 8'h00);
    chk("rst_dr", dr, 8'h00);
    chk("rst_e", e, 1'b0);
    chk("rst_ctl", {mem_rd_req, busy, done, err}, 4'b0000);
    chk("rst_strb", w_strb, 6'b0);
    rst = 1'b0;
    tick();

    // 1: LDA 0x10 with ack one cycle later, done at cycle 3
    issue(4'd2, 8'h10);
    chk("lda_req", {mem_rd_req, busy, done}, 3'b110);
    chk("lda_addr", mem_addr, 8'h10);
    ack_with(8'h5A);
    chk("lda_strb", w_strb, 6'b001000);
    chk("lda_dr", dr, 8'h5A);
    chk("lda_nodone2", done, 1'b0);
    tick();
    chk("lda_done3", {done, err, busy}, 3'b100);
    chk("lda_ac", ac, 8'h5A);

    // 2: 0xF0 + 0x20 -> 0x10 with carry
    load_ac(8'hF0);
    issue(4'd7, 8'h00);
    chk("cle_done1", {done, err, e}, 3'b100);
    issue(4'd1, 8'h77);
    ack_with(8'h20);
    chk("add_strb", w_strb, 6'b010000);
    tick();
    chk("add_strb_off", w_strb, 6'b000000);
    chk("add_ac", ac, 8'h10);
    chk("add_e", e, 1'b1);
    chk("add_done", done, 1'b1);

    // 3: CIR then CIL, each issued on the cycle the previous done is high
    load_ac(8'h81);
    issue(4'd7, 8'h00);
    issue(4'd4, 8'h00);
    chk("cir_strb", w_strb, 6'b000010);
    chk("cir_nodone1", done, 1'b0);
    tick();
    chk("cir_res", {done, e, ac}, {1'b1, 1'b1, 8'h40});
    issue(4'd5, 8'h00);
    chk("cil_strb", w_strb, 6'b000001);
    tick();
    chk("cil_res", {done, e, ac}, {1'b1, 1'b0, 8'h81});
    issue(4'd3, 8'h00);
    tick();
    chk("cma_ac", ac, 8'h7E);
    issue(4'd0, 8'h00);
    ack_with(8'h0F);
    chk("and_strb", w_strb, 6'b100000);
    tick();
    chk("and_ac", ac, 8'h0E);
    issue(4'd8, 8'h00);
    chk("cme_e", {done, e}, 2'b11);
    issue(4'd6, 8'h00);
    chk("cla_ac", {done, err, ac}, {2'b10, 8'h00});

    // 4: illegal opcode, then start while busy is ignored
    load_ac(8'hA5);
    issue(4'hC, 8'h00);
    chk("ill_done_err", {done, err, busy}, 3'b110);
    chk("ill_regs", {e, ac}, {1'b1, 8'hA5});
    issue(4'd2, 8'h33);
    issue(4'd6, 8'h44);
    chk("busy_ign_req", {mem_rd_req, busy, done}, 3'b110);
    chk("busy_ign_addr", mem_addr, 8'h33);
    ack_with(8'h3C);
    tick();
    chk("busy_ign_ac", {done, ac}, {1'b1, 8'h3C});
    tick();
    chk("busy_ign_quiet", {done, busy}, 2'b00);

    // Ack outside FETCH does not touch DR
    ack_with(8'hFF);
    chk("idle_ack_dr", dr, 8'h3C);

    // 5: reset in the middle of FETCH
    issue(4'd2, 8'h20);
    tick(); tick();
    chk("pre_rst_req", mem_rd_req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ctl", {mem_rd_req, busy, done}, 3'b000);
    chk("midrst_ac", ac, 8'h00);
    tick();
    chk("midrst_nodone", {done, busy}, 2'b00);

`ifdef MEM_TIMEOUT_EN
    // 6: ack withheld -> done+err after 15 FETCH cycles
    load_ac(8'h3C);
    issue(4'd2, 8'h50);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, 15);
    chk("tmo_flags", {done, err, busy, mem_rd_req}, 4'b1100);
    chk("tmo_ac", ac, 8'h3C);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
